// File: rtl/ir_pipe_stages.sv
// ir_pipe_stages: elastic instruction-register pipeline of DEPTH stages.
// Each stage holds one instruction word and one valid bit. The chain runs
// at full rate: a stage reloads when it is empty or its contents leave in
// the same cycle, so bubbles collapse even while the output is stalled.
// Empty stages always hold the NOP word.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is computed from registered state and out_ready only;
// out_valid/out_instr come straight from the last-stage registers.
//
// Optional feature: define IR_PIPE_DBG_HALT_EN to add the dbg_halt input.
// While it is 1, all stages freeze, in_ready is 0 and out_valid reads 0.
// reset_stages (synchronous flush) takes priority over dbg_halt.
module ir_pipe_stages #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3,
  parameter logic [WIDTH-1:0] NOP = WIDTH'(32'h00000013)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             reset_stages,
`ifdef IR_PIPE_DBG_HALT_EN
  input  logic             dbg_halt,
`endif
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_instr,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_instr,
  input  logic             out_ready,
  output logic [DEPTH-1:0] stage_valid
);

  logic             halt;
  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] word_q [DEPTH];
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] src_valid;
  logic [WIDTH-1:0] src_word [DEPTH];
  logic             out_xfer;
  logic             in_xfer;

`ifdef IR_PIPE_DBG_HALT_EN
  assign halt = dbg_halt;
`else
  assign halt = 1'b0;
`endif

  // The last stage is presented downstream; a halted pipe shows no valid
  // output and a NOP word while still keeping the stage contents.
  assign out_valid = valid_q[DEPTH-1] & ~halt;
  assign out_instr = out_valid ? word_q[DEPTH-1] : NOP;
  assign out_xfer  = out_valid & out_ready;

  // Load enables, resolved from the output end backwards: a stage may load
  // when it is empty or when the stage ahead of it loads (its contents move).
  always_comb begin
    load = '0;
    load[DEPTH-1] = ~valid_q[DEPTH-1] | out_xfer;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      load[i] = ~valid_q[i] | load[i+1];
    end
    if (halt) begin
      load = '0;
    end
  end

  // Stage 0 accepts only outside reset, flush and halt.
  assign in_ready    = reset_n & ~reset_stages & ~halt & load[0];
  assign in_xfer     = in_valid & in_ready;
  assign stage_valid = valid_q;

  // What each stage takes when it loads; an invalid source is always NOP,
  // so a stage whose contents leave with nothing behind becomes a bubble.
  always_comb begin
    src_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      src_word[i] = NOP;
    end
    src_valid[0] = in_xfer;
    src_word[0]  = in_xfer ? in_instr : NOP;
    for (int i = 1; i < DEPTH; i++) begin
      src_valid[i] = valid_q[i-1];
      src_word[i]  = word_q[i-1];
    end
  end

  // Stage registers: async reset and sync flush both empty every stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= NOP;
      end
    end else if (reset_stages) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= NOP;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (load[i]) begin
          valid_q[i] <= src_valid[i];
          word_q[i]  <= src_word[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_ir_pipe_stages.sv
// Bench for ir_pipe_stages (DEPTH=3, WIDTH=32). Accepted words are queued
// on each input transfer and popped on each output transfer; directed
// sequences cover reset, latency, backpressure, bubble collapse, flush,
// halt (when IR_PIPE_DBG_HALT_EN is defined) and a random phase.
module tb_ir_pipe_stages;
  localparam int W = 32;
  localparam int D = 3;
  localparam logic [W-1:0] NOP_W = 32'h00000013;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         reset_stages;
  logic         in_valid;
  logic [W-1:0] in_instr;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_instr;
  logic         out_ready;
  logic [D-1:0] stage_valid;
  logic         halt_now;

  int n_vec = 0;
  int n_err = 0;
  int out_cnt = 0;
  int acc_cnt = 0;
  int c0;
  int a0;
  logic [W-1:0] exp_q[$];

`ifdef IR_PIPE_DBG_HALT_EN
  logic dbg_halt;
  assign halt_now = dbg_halt;
`else
  assign halt_now = 1'b0;
`endif

  // clock / reset block
  always #5 clk = ~clk;

  ir_pipe_stages #(.WIDTH(W), .DEPTH(D), .NOP(NOP_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .reset_stages (reset_stages),
`ifdef IR_PIPE_DBG_HALT_EN
    .dbg_halt     (dbg_halt),
`endif
    .in_valid     (in_valid),
    .in_instr     (in_instr),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_instr    (out_instr),
    .out_ready    (out_ready),
    .stage_valid  (stage_valid)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] w, input logic rdy);
    in_valid  = v;
    in_instr  = w;
    out_ready = rdy;
  endtask

  // Scoreboard: sampled mid-cycle, ahead of the edge that commits transfers.
  always @(negedge clk) begin
    logic exp_rdy;
    if (!reset_n) begin
      exp_q.delete();
    end else begin
      exp_rdy = !reset_stages && !halt_now && !(exp_q.size() == D && !out_ready);
      check("mon_in_ready", W'(in_ready), W'(exp_rdy));
      check("mon_occupancy", W'($countones(stage_valid)), W'(exp_q.size()));
      if (!out_valid) check("mon_idle_word", out_instr, NOP_W);
      if (halt_now) check("mon_halt_out_valid", W'(out_valid), W'(0));
      if (out_valid && out_ready) begin
        out_cnt++;
        check("mon_q_nonempty", W'(exp_q.size() != 0), W'(1));
        if (exp_q.size() != 0) check("mon_data", out_instr, exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        acc_cnt++;
        exp_q.push_back(in_instr);
      end
      if (reset_stages) exp_q.delete();
    end
  end

  initial begin
    reset_n      = 1'b0;
    reset_stages = 1'b0;
    drive(1'b0, '0, 1'b0);
`ifdef IR_PIPE_DBG_HALT_EN
    dbg_halt = 1'b0;
`endif
    #2;
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_out_instr", out_instr, NOP_W);
    check("rst_stage_valid", W'(stage_valid), W'(0));
    check("rst_in_ready", W'(in_ready), W'(0));
    @(posedge clk);
    #1 reset_n = 1'b1;
    #1 check("rst_release_ready", W'(in_ready), W'(1));

    // streaming: out_valid 2 edges after first accept, back-to-back words
    drive(1'b1, 32'hA1, 1'b1);
    step();
    check("str_lat0", W'(out_valid), W'(0));
    drive(1'b1, 32'hA2, 1'b1);
    step();
    check("str_lat1", W'(out_valid), W'(0));
    drive(1'b1, 32'hA3, 1'b1);
    step();
    check("str_first_valid", W'(out_valid), W'(1));
    check("str_first_word", out_instr, 32'hA1);
    drive(1'b0, '0, 1'b1);
    step();
    check("str_second_word", out_instr, 32'hA2);
    step();
    check("str_third_word", out_instr, 32'hA3);
    step();
    check("str_done_valid", W'(out_valid), W'(0));
    check("str_done_word", out_instr, NOP_W);

    // backpressure
    drive(1'b1, 32'hA1, 1'b0);
    step();
    drive(1'b1, 32'hA2, 1'b0);
    step();
    drive(1'b1, 32'hA3, 1'b0);
    step();
    check("bp_full", W'(stage_valid), W'(3'b111));
    check("bp_ready_low", W'(in_ready), W'(0));
    drive(1'b1, 32'hA4, 1'b1);
    c0 = out_cnt;
    a0 = acc_cnt;
    step();
    check("bp_one_out", W'(out_cnt - c0), W'(1));
    check("bp_one_acc", W'(acc_cnt - a0), W'(1));
    check("bp_still_full", W'(stage_valid), W'(3'b111));
    check("bp_next_word", out_instr, 32'hA2);
    drive(1'b0, '0, 1'b0);
    step();
    check("bp_no_more_out", W'(out_cnt - c0), W'(1));
    drive(1'b0, '0, 1'b1);
    repeat (4) step();
    check("bp_drained", W'(stage_valid), W'(0));

    // bubble collapse: stages 0 and 2 valid, middle empty, output stalled
    drive(1'b1, 32'hB1, 1'b0);
    step();
    drive(1'b0, '0, 1'b0);
    step();
    step();
    check("bub_pre", W'(stage_valid), W'(3'b100));
    drive(1'b1, 32'hB2, 1'b0);
    step();
    drive(1'b0, '0, 1'b0);
    check("bub_gap", W'(stage_valid), W'(3'b101));
    check("bub_ready0", W'(in_ready), W'(1));
    step();
    check("bub_move", W'(stage_valid), W'(3'b110));
    check("bub_ready1", W'(in_ready), W'(1));
    drive(1'b0, '0, 1'b1);
    repeat (3) step();

    // flush of a full pipe with simultaneous output transfer and input
    drive(1'b1, 32'hC1, 1'b0);
    step();
    drive(1'b1, 32'hC2, 1'b0);
    step();
    drive(1'b1, 32'hC3, 1'b0);
    step();
    c0 = out_cnt;
    reset_stages = 1'b1;
    drive(1'b1, 32'hC4, 1'b1);
    #1 check("fl_ready_low", W'(in_ready), W'(0));
    step();
    check("fl_out_done", W'(out_cnt - c0), W'(1));
    check("fl_empty", W'(stage_valid), W'(0));
    check("fl_out_valid", W'(out_valid), W'(0));
    check("fl_out_word", out_instr, NOP_W);
    for (int k = 0; k < 2; k++) begin
      step();
      check("fl_hold_ready", W'(in_ready), W'(0));
      check("fl_hold_empty", W'(stage_valid), W'(0));
    end
    reset_stages = 1'b0;
    drive(1'b0, '0, 1'b1);
    step();

`ifdef IR_PIPE_DBG_HALT_EN
    // halt during streaming, then release, then flush while halted
    drive(1'b1, 32'hD1, 1'b1);
    step();
    drive(1'b1, 32'hD2, 1'b1);
    step();
    dbg_halt = 1'b1;
    drive(1'b1, 32'hD3, 1'b1);
    #1 check("halt_out_valid", W'(out_valid), W'(0));
    check("halt_ready", W'(in_ready), W'(0));
    step();
    step();
    check("halt_keep", W'(stage_valid), W'(3'b011));
    dbg_halt = 1'b0;
    drive(1'b0, '0, 1'b1);
    repeat (4) step();
    check("halt_resume_empty", W'(stage_valid), W'(0));
    drive(1'b1, 32'hE1, 1'b0);
    step();
    dbg_halt = 1'b1;
    reset_stages = 1'b1;
    drive(1'b0, '0, 1'b0);
    step();
    check("halt_flush_empty", W'(stage_valid), W'(0));
    dbg_halt = 1'b0;
    reset_stages = 1'b0;
    step();
`endif

    // async reset with full pipe, asserted mid-cycle
    drive(1'b1, 32'hF1, 1'b0);
    step();
    drive(1'b1, 32'hF2, 1'b0);
    step();
    drive(1'b1, 32'hF3, 1'b0);
    step();
    drive(1'b0, '0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("arst_out_valid", W'(out_valid), W'(0));
    check("arst_out_instr", out_instr, NOP_W);
    check("arst_stage_valid", W'(stage_valid), W'(0));
    check("arst_in_ready", W'(in_ready), W'(0));
    @(posedge clk);
    #1 reset_n = 1'b1;
    #1 check("arst_release_ready", W'(in_ready), W'(1));

    // random traffic
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0));
      reset_stages = ($urandom_range(0, 31) == 0);
`ifdef IR_PIPE_DBG_HALT_EN
      dbg_halt = ($urandom_range(0, 15) == 0);
`endif
      step();
    end
    reset_stages = 1'b0;
`ifdef IR_PIPE_DBG_HALT_EN
    dbg_halt = 1'b0;
`endif
    drive(1'b0, '0, 1'b1);
    repeat (5) step();
    check("final_empty", W'(stage_valid), W'(0));
    check("final_queue", W'(exp_q.size()), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
